// File: rtl/w_pipe_reg.sv
// M/W pipeline register: captures the M-stage result into W, qualifies the GRF
// write, exposes the W forwarding tag and counts retired instructions.
module w_pipe_reg #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             M_valid,
    input  logic [31:0]      M_instr,
    input  logic [31:0]      M_PC,
    input  logic [4:0]       M_GRF_A3,
    input  logic             M_GRF_WE,
    input  logic [31:0]      M_GRF_Wdata,
    output logic [31:0]      W_instr,
    output logic [31:0]      W_PC,
    output logic [4:0]       W_GRF_A3,
    output logic             W_GRF_WE,
    output logic [31:0]      W_GRF_Wdata,
    output logic             W_valid,
    output logic [4:0]       W_fwd_addr,
    output logic [31:0]      W_fwd_data,
    output logic [CNT_W-1:0] retire_cnt
);

    logic [31:0]      r_instr;
    logic [31:0]      r_pc;
    logic [4:0]       r_a3;
    logic             r_we;
    logic [31:0]      r_wdata;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_wq;

    // Bubbles and writes to $0 never become real GRF writes or forwarding tags.
    assign w_wq = M_GRF_WE & M_valid & (M_GRF_A3 != 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_a3    <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_a3    <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_instr <= M_instr;
            r_pc    <= M_PC;
            r_a3    <= w_wq ? M_GRF_A3 : 5'd0;
            r_we    <= w_wq;
            r_wdata <= M_GRF_Wdata;
            r_valid <= M_valid;
            if (M_valid)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign W_instr     = r_instr;
    assign W_PC        = r_pc;
    assign W_GRF_A3    = r_a3;
    assign W_GRF_WE    = r_we;
    assign W_GRF_Wdata = r_wdata;
    assign W_valid     = r_valid;
    assign retire_cnt  = r_cnt;
    assign W_fwd_addr  = r_we ? r_a3 : 5'd0;
    assign W_fwd_data  = r_wdata;

endmodule

// File: tb/tb_w_pipe_reg.sv
// Scoreboard bench for w_pipe_reg: stimulus pushes the expected W state per edge,
// a monitor pops and compares one step after each rising edge.
module tb_w_pipe_reg;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  a3;
        logic        we;
        logic [31:0] wdata;
        logic        valid;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } wstate_t;

    logic        clk = 1'b0;
    logic        reset, en, flush, M_valid, M_GRF_WE;
    logic [31:0] M_instr, M_PC, M_GRF_Wdata;
    logic [4:0]  M_GRF_A3;

    logic [31:0] W_instr, W_PC, W_GRF_Wdata, W_fwd_data, retire_cnt;
    logic [4:0]  W_GRF_A3, W_fwd_addr;
    logic        W_GRF_WE, W_valid;

    logic [31:0] W4_instr, W4_PC, W4_GRF_Wdata, W4_fwd_data;
    logic [4:0]  W4_GRF_A3, W4_fwd_addr;
    logic        W4_GRF_WE, W4_valid;
    logic [3:0]  retire_cnt4;

    int tests = 0;
    int fails = 0;
    wstate_t sb_q[$];
    wstate_t model;

    always #5 clk = ~clk;

    w_pipe_reg #(.CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .M_valid(M_valid),
        .M_instr(M_instr), .M_PC(M_PC), .M_GRF_A3(M_GRF_A3), .M_GRF_WE(M_GRF_WE),
        .M_GRF_Wdata(M_GRF_Wdata), .W_instr(W_instr), .W_PC(W_PC), .W_GRF_A3(W_GRF_A3),
        .W_GRF_WE(W_GRF_WE), .W_GRF_Wdata(W_GRF_Wdata), .W_valid(W_valid),
        .W_fwd_addr(W_fwd_addr), .W_fwd_data(W_fwd_data), .retire_cnt(retire_cnt)
    );

    w_pipe_reg #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .M_valid(M_valid),
        .M_instr(M_instr), .M_PC(M_PC), .M_GRF_A3(M_GRF_A3), .M_GRF_WE(M_GRF_WE),
        .M_GRF_Wdata(M_GRF_Wdata), .W_instr(W4_instr), .W_PC(W4_PC), .W_GRF_A3(W4_GRF_A3),
        .W_GRF_WE(W4_GRF_WE), .W_GRF_Wdata(W4_GRF_Wdata), .W_valid(W4_valid),
        .W_fwd_addr(W4_fwd_addr), .W_fwd_data(W4_fwd_data), .retire_cnt(retire_cnt4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: apply the edge rules (reset > flush > en) to the abstract W state.
    task automatic drive(input logic rst, input logic fl, input logic e, input logic v,
                         input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] a3,
                         input logic we, input logic [31:0] wd);
        wstate_t n;
        reset = rst; flush = fl; en = e; M_valid = v;
        M_instr = ins; M_PC = pc; M_GRF_A3 = a3; M_GRF_WE = we; M_GRF_Wdata = wd;
        n = model;
        if (!rst) begin
            n = '{32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0};
        end else if (fl) begin
            n.instr = 0; n.pc = 0; n.a3 = 0; n.we = 0; n.wdata = 0; n.valid = 0;
        end else if (e) begin
            n.instr = ins; n.pc = pc; n.wdata = wd; n.valid = v;
            n.we = we && v && (a3 != 0);
            n.a3 = n.we ? a3 : 5'd0;
            if (v) begin
                n.cnt  = model.cnt + 1;
                n.cnt4 = model.cnt4 + 4'd1;
            end
        end
        model = n;
        sb_q.push_back(n);
        @(negedge clk);
    endtask

    task automatic drive_rnd(input logic rst, input logic fl, input logic e, input logic v);
        drive(rst, fl, e, v, $urandom, $urandom, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), $urandom);
    endtask

    initial begin : monitor
        wstate_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                chk("W_instr", 64'(W_instr), 64'(x.instr));
                chk("W_PC", 64'(W_PC), 64'(x.pc));
                chk("W_GRF_A3", 64'(W_GRF_A3), 64'(x.a3));
                chk("W_GRF_WE", 64'(W_GRF_WE), 64'(x.we));
                chk("W_GRF_Wdata", 64'(W_GRF_Wdata), 64'(x.wdata));
                chk("W_valid", 64'(W_valid), 64'(x.valid));
                chk("W_fwd_addr", 64'(W_fwd_addr), 64'(x.we ? x.a3 : 5'd0));
                chk("W_fwd_data", 64'(W_fwd_data), 64'(x.wdata));
                chk("retire_cnt", 64'(retire_cnt), 64'(x.cnt));
                chk("retire_cnt4", 64'(retire_cnt4), 64'(x.cnt4));
            end
        end
    end

    initial begin : stim
        model = '{32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0};
        reset = 0; flush = 0; en = 0; M_valid = 0; M_GRF_WE = 0;
        M_instr = 0; M_PC = 0; M_GRF_A3 = 0; M_GRF_Wdata = 0;
        @(negedge clk);

        // Reset overrides flush/en with a valid M instruction.
        drive(0, 1, 1, 1, 32'hDEAD_BEEF, 32'h3004, 5'd9, 1, 32'h55);
        drive(0, 1, 1, 1, 32'hDEAD_BEEF, 32'h3004, 5'd9, 1, 32'h55);
        chk("rst_valid", 64'(W_valid), 64'd0);
        chk("rst_fwd_addr", 64'(W_fwd_addr), 64'd0);
        chk("rst_cnt", 64'(retire_cnt), 64'd0);

        drive(1, 0, 1, 1, 32'h0123_4567, 32'h3000, 5'd5, 1, 32'h0000_1234);
        chk("cap_we", 64'(W_GRF_WE), 64'd1);
        chk("cap_a3", 64'(W_GRF_A3), 64'd5);
        chk("cap_fwd_addr", 64'(W_fwd_addr), 64'd5);
        chk("cap_fwd_data", 64'(W_fwd_data), 64'h1234);
        chk("cap_cnt", 64'(retire_cnt), 64'd1);

        drive(1, 0, 1, 1, 32'h1111_2222, 32'h3004, 5'd0, 1, 32'hFFFF_FFFF);
        chk("r0_we", 64'(W_GRF_WE), 64'd0);
        chk("r0_fwd_addr", 64'(W_fwd_addr), 64'd0);
        chk("r0_valid", 64'(W_valid), 64'd1);
        chk("r0_cnt", 64'(retire_cnt), 64'd2);

        drive(1, 0, 1, 1, 32'hAC00_0000, 32'h3008, 5'd9, 0, 32'h77);
        chk("sw_valid", 64'(W_valid), 64'd1);
        chk("sw_we", 64'(W_GRF_WE), 64'd0);
        chk("sw_a3", 64'(W_GRF_A3), 64'd0);
        chk("sw_cnt", 64'(retire_cnt), 64'd3);

        drive(1, 0, 1, 1, 32'h2222_3333, 32'h300C, 5'd7, 1, 32'hAAAA);
        for (int i = 0; i < 3; i++) begin
            drive_rnd(1, 0, 0, 1);
            chk("stall_a3", 64'(W_fwd_addr), 64'd7);
            chk("stall_cnt", 64'(retire_cnt), 64'd4);
        end
        drive_rnd(1, 1, 0, 1);
        chk("flush_valid", 64'(W_valid), 64'd0);
        chk("flush_we", 64'(W_GRF_WE), 64'd0);
        chk("flush_fwd_addr", 64'(W_fwd_addr), 64'd0);
        chk("flush_cnt", 64'(retire_cnt), 64'd4);

        drive_rnd(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive_rnd(1, 0, 1, 1);
        chk("stream_cnt", 64'(retire_cnt), 64'd8);
        for (int i = 0; i < 7; i++) drive_rnd(1, 0, 1, 1);
        chk("wrap_cnt4_15", 64'(retire_cnt4), 64'd15);
        drive_rnd(1, 0, 1, 1);
        chk("wrap_cnt4_0", 64'(retire_cnt4), 64'd0);
        chk("wrap_cnt32", 64'(retire_cnt), 64'd16);

        for (int i = 0; i < 400; i++)
            drive_rnd($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 10,
                      $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 80);

        @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/w_pipe_reg.md
W_PIPE_REG -- requirements
Module: w_pipe_reg

Interface
REQ-001 Parameter: CNT_W, 32, width of the retired-instruction counter.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock, only clock of the block.
REQ-004 reset  input  1  synchronous active-low reset (0 = reset, sampled on rising clk).
REQ-005 en  input  1  M/W advance enable; 0 = stall (hold W contents).
REQ-006 flush  input  1  replace incoming M instruction with a bubble.
REQ-007 M_valid  input  1  M stage holds a real instruction (0 = bubble).
REQ-008 M_instr  input  32  M-stage instruction word.
REQ-009 M_PC  input  32  M-stage PC.
REQ-010 M_GRF_A3  input  5  M-stage GRF destination register.
REQ-011 M_GRF_WE  input  1  M-stage GRF write request.
REQ-012 M_GRF_Wdata  input  32  M-stage selected write-back data (ALU result, load data or PC+8).
REQ-013 W_instr, W_PC  output  32 each  registered copies for W stage.
REQ-014 W_GRF_A3  output  5  registered destination register.
REQ-015 W_GRF_WE  output  1  GRF write enable, registered.
REQ-016 W_GRF_Wdata  output  32  GRF write data, registered.
REQ-017 W_valid  output  1  W stage holds a real instruction.
REQ-018 W_fwd_addr  output  5  forwarding tag for D/E/M bypass; 0 = nothing to forward.
REQ-019 W_fwd_data  output  32  forwarding data.
REQ-020 retire_cnt  output  CNT_W  count of valid instructions captured into W.

Function
REQ-021 All W_* registers and retire_cnt SHALL update only on rising clk; latency M->W is exactly 1 cycle.
REQ-022 Priority per edge SHALL be: reset, then flush, then en.
REQ-023 flush=1 (reset=1): load bubble -- W_instr=0, W_PC=0, W_GRF_A3=0, W_GRF_WE=0, W_GRF_Wdata=0, W_valid=0, regardless of en.
REQ-024 flush=0, en=0: every W register and retire_cnt SHALL hold its value.
REQ-025 flush=0, en=1: W_instr<=M_instr, W_PC<=M_PC, W_GRF_Wdata<=M_GRF_Wdata, W_valid<=M_valid.
REQ-026 On capture, write qualification wq = M_GRF_WE & M_valid & (M_GRF_A3 != 0); W_GRF_WE<=wq.
REQ-027 On capture, W_GRF_A3<=M_GRF_A3 if wq=1, else 0 (writes to $0 and bubbles never carry a tag).
REQ-028 W_fwd_addr SHALL be combinational: W_GRF_WE ? W_GRF_A3 : 0; W_fwd_data = W_GRF_Wdata unconditionally.
REQ-029 retire_cnt SHALL increment by 1 on each edge with reset=1, flush=0, en=1, M_valid=1; otherwise hold.
REQ-030 retire_cnt SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-031 A valid instruction with M_GRF_WE=0 (e.g. sw, beq) SHALL set W_valid=1, W_GRF_WE=0, W_GRF_A3=0 and still count.
REQ-032 Back-to-back captures SHALL sustain one instruction per cycle with no bubble inserted by the block.
REQ-033 Outputs SHALL be glitch-free registered values except W_fwd_addr/W_fwd_data (combinational from registers only, no input-to-output path).

Reset
REQ-034 reset=0 at an edge SHALL clear all W_* registers to 0 and retire_cnt to 0, overriding flush and en.
REQ-035 Reset asserted mid-stall SHALL still clear everything on the next edge; first capture occurs on the first edge with reset=1, en=1.
REQ-036 With reset=0 held, W_fwd_addr SHALL read 0 from the first post-reset edge on.

Verification
REQ-037 Capture: M_valid=1, A3=5, WE=1, Wdata=0x0000_1234, PC=0x3000, en=1 -> next cycle W_GRF_WE=1, W_GRF_A3=5, W_fwd_addr=5, W_fwd_data=0x1234, retire_cnt=1.
REQ-038 $0 write: A3=0, WE=1, Wdata=0xFFFF_FFFF -> W_GRF_WE=0, W_fwd_addr=0, W_valid=1, retire_cnt increments.
REQ-039 Stall then flush: capture A3=7, hold en=0 three cycles -> outputs unchanged, count unchanged; then flush=1, en=0 -> W_valid=0, W_GRF_WE=0, W_fwd_addr=0.
REQ-040 Priority: reset=0 with flush=1, en=1, valid M input -> all outputs 0, retire_cnt=0.
REQ-041 Wrap: CNT_W=4, 16 consecutive valid captures -> retire_cnt goes 15 then 0.
REQ-042 Streaming: 8 valid instructions on consecutive cycles with en=1 -> W sequence equals M sequence delayed one cycle, retire_cnt=8.
